cdb_complete_arbiter: RTL

Parametrised complete stage sitting between the execute-stage functional units (FUs) and the common data bus (CDB). Each of NUM_FU result channels gets a small FIFO with valid/ready backpressure. A round-robin arbiter drains up to CDB_WIDTH FIFO heads per cycle onto registered CDB lanes, so FUs can outnumber CDB slots without losing results. Rollback flushes all buffered and in-flight results.

---
 rtl/cdb_complete_arbiter_pkg.sv | 41 ++++
 rtl/cdb_complete_arbiter_fifo.sv | 72 +++++++
 rtl/cdb_complete_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cdb_complete_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_complete_arbiter_pkg
//   Shared machine-wide widths and the two packet formats exchanged between
//   the execute stage and the common data bus.
//     EX_COMPLETE : FU result packet (PR, result, halt, w, r)
//     CDB         : broadcast lane tag (PR, completed, halt, w, r)
//   rr_index    : modular scan helper for round-robin arbitration.
// -----------------------------------------------------------------------------
package cdb_complete_arbiter_pkg;

    localparam int unsigned WIDTH    = 2;
    localparam int unsigned PRF_SIZE = 64;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned PR_W     = $clog2(PRF_SIZE);

    typedef struct packed {
        logic [PR_W-1:0] pr;
        logic [XLEN-1:0] result;
        logic            halt;
        logic            w;
        logic            r;
    } EX_COMPLETE;

    typedef struct packed {
        logic [PR_W-1:0] pr;
        logic            completed;
        logic            halt;
        logic            w;
        logic            r;
    } CDB;

    // (base + off) mod n, valid for base < n and off < n.
    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/cdb_complete_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// complete_fifo
//   BUF_DEPTH-entry circular FIFO of EX_COMPLETE packets for one FU channel.
//     i_clock  : clock
//     i_flush  : synchronous clear of all entries (wins over push/pop)
//     i_push   : write i_data (ignored when full)
//     i_data   : packet to enqueue
//     i_pop    : drop head (ignored when empty)
//     o_head   : current head packet
//     o_count  : entries held
//     o_full   : count == BUF_DEPTH
//     o_empty  : count == 0
// -----------------------------------------------------------------------------
module complete_fifo
    import cdb_complete_arbiter_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                             i_clock,
    input  logic                             i_flush,
    input  logic                             i_push,
    input  EX_COMPLETE                       i_data,
    input  logic                             i_pop,
    output EX_COMPLETE                       o_head,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   o_count,
    output logic                             o_full,
    output logic                             o_empty
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    EX_COMPLETE        r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CNT_W'(BUF_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clock) begin
        if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge i_clock) begin
        if (!i_flush && w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/cdb_complete_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_complete_arbiter
//   Complete stage: one FIFO per FU result channel, round-robin drain of up to
//   CDB_WIDTH FIFO heads per cycle onto registered CDB lanes.
//     clock, reset  : clock, synchronous active-high reset
//     rollback_en   : flush FIFOs, CDB registers and round-robin pointer
//     fu_valid      : FU i presents fu_packet[i]
//     fu_packet     : per-FU result packet
//     fu_ready      : FIFO i not full (registered-count based)
//     cdb           : registered broadcast tag per lane
//     result        : registered result value per lane
//     occupancy     : entries held per FIFO
// -----------------------------------------------------------------------------
module cdb_complete_arbiter
    import cdb_complete_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU    = 6,
    parameter int unsigned CDB_WIDTH = WIDTH,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          rollback_en,
    input  logic [NUM_FU-1:0]                             fu_valid,
    input  EX_COMPLETE [NUM_FU-1:0]                       fu_packet,
    output logic [NUM_FU-1:0]                             fu_ready,
    output CDB [CDB_WIDTH-1:0]                            cdb,
    output logic [CDB_WIDTH-1:0][XLEN-1:0]                result,
    output logic [NUM_FU-1:0][$clog2(BUF_DEPTH+1)-1:0]    occupancy
);

    localparam int unsigned IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int unsigned GNT_W = $clog2(CDB_WIDTH + 1);

    logic                  w_flush;
    logic [NUM_FU-1:0]     w_full;
    logic [NUM_FU-1:0]     w_empty;
    logic [NUM_FU-1:0]     w_grant;
    EX_COMPLETE            w_head [NUM_FU];

    logic [IDX_W-1:0]      w_lane_sel [CDB_WIDTH];
    logic [CDB_WIDTH-1:0]  w_lane_vld;
    logic [IDX_W-1:0]      w_scan;
    logic [IDX_W-1:0]      w_last;
    logic [GNT_W-1:0]      w_n;
    logic                  w_any;

    logic [IDX_W-1:0]              r_rr_ptr;
    CDB [CDB_WIDTH-1:0]            r_cdb;
    logic [CDB_WIDTH-1:0][XLEN-1:0] r_result;

    assign w_flush  = reset || rollback_en;
    assign fu_ready = ~w_full;
    assign cdb      = r_cdb;
    assign result   = r_result;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
        complete_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
            .i_clock (clock),
            .i_flush (w_flush),
            .i_push  (fu_valid[i] && fu_ready[i]),
            .i_data  (fu_packet[i]),
            .i_pop   (w_grant[i]),
            .o_head  (w_head[i]),
            .o_count (occupancy[i]),
            .o_full  (w_full[i]),
            .o_empty (w_empty[i])
        );
    end

    // Scan from r_rr_ptr; the n-th non-empty FIFO found is bound to lane n.
    always_comb begin
        w_grant    = '0;
        w_lane_vld = '0;
        w_any      = 1'b0;
        w_last     = '0;
        w_scan     = '0;
        w_n        = '0;
        for (int unsigned k = 0; k < CDB_WIDTH; k++) w_lane_sel[k] = '0;
        for (int unsigned j = 0; j < NUM_FU; j++) begin
            w_scan = IDX_W'(rr_index(32'(r_rr_ptr), j, NUM_FU));
            if (!w_empty[w_scan] && (w_n < GNT_W'(CDB_WIDTH))) begin
                for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
                    if (GNT_W'(k) == w_n) begin
                        w_lane_sel[k] = w_scan;
                        w_lane_vld[k] = 1'b1;
                    end
                end
                w_grant[w_scan] = 1'b1;
                w_any           = 1'b1;
                w_last          = w_scan;
                w_n             = w_n + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || rollback_en) begin
            r_cdb    <= '0;
            r_result <= '0;
            r_rr_ptr <= '0;
        end else begin
            for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
                if (w_lane_vld[k]) begin
                    r_cdb[k].pr        <= w_head[w_lane_sel[k]].pr;
                    r_cdb[k].completed <= 1'b1;
                    r_cdb[k].halt      <= w_head[w_lane_sel[k]].halt;
                    r_cdb[k].w         <= w_head[w_lane_sel[k]].w;
                    r_cdb[k].r         <= w_head[w_lane_sel[k]].r;
                    r_result[k]        <= w_head[w_lane_sel[k]].result;
                end else begin
                    r_cdb[k]    <= '0;
                    r_result[k] <= '0;
                end
            end
            if (w_any) begin
                r_rr_ptr <= (w_last == IDX_W'(NUM_FU - 1)) ? '0 : w_last + 1'b1;
            end
        end
    end

endmodule
